// File: rtl/seq_bit_serializer.sv
// Parallel-in, serial-out front end for the sequence detector: a one-word hold
// buffer feeds a shift register so consecutive words stream with no idle bit.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST_CNT = CW'(WIDTH - 2);

    localparam logic [0:0] IDLE_ST  = 1'b0;
    localparam logic [0:0] SHIFT_ST = 1'b1;

    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    count;
    logic [0:0]       state;

    logic accept;
    logic last;
    logic load;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign in_ready = ~hold_full & ~reset;
    assign accept   = in_valid & in_ready;
    assign last     = (state == SHIFT_ST) && (count == LAST_CNT);
    // A held word moves into the shifter either from idle or on the last-bit edge,
    // which is what keeps back-to-back words gapless.
    assign load     = hold_full && ((state == IDLE_ST) || last);
    assign busy     = (state == SHIFT_ST) | hold_full;

    // Accept only happens with the hold empty and load only with it full, so the
    // two branches can never both apply in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // x always shows the bit the counter points at; the next bit is taken from
    // the shift register position that becomes the output end after this shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE_ST;
            shift     <= '0;
            count     <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end else if (load) begin
            state     <= SHIFT_ST;
            shift     <= hold;
            count     <= '0;
            x         <= first_bit(hold);
            x_valid   <= 1'b1;
            word_done <= 1'b0;
        end else if (last) begin
            state     <= IDLE_ST;
            count     <= '0;
            x         <= IDLE_BIT;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end else if (state == SHIFT_ST) begin
            shift     <= MSB_FIRST ? (shift << 1) : (shift >> 1);
            count     <= count + 1'b1;
            x         <= MSB_FIRST ? shift[WIDTH-2] : shift[1];
            x_valid   <= 1'b1;
            word_done <= (count == PRELAST_CNT);
        end
    end

endmodule
